// File: rtl/requant_seq_ctrl.sv
// requant_seq_ctrl
//   Job sequencer for a 16-lane, 3-stage requantizer datapath. For each job it
//   latches the requant config, fetches one bias vector, streams cfg_rows
//   accumulator vectors into the requantizer, and writes the quantized results
//   to the output buffer over a valid/ready port. The requantizer cannot stall,
//   so results land in an internal FIFO and accumulator reads are only issued
//   while FIFO occupancy plus in-flight vectors leaves room for them.
//
// Ports:
//   CLK, RESET                      clock, async active-low reset
//   start, cfg_*                    job start pulse and job config (sampled in IDLE)
//   acc_rd_en/addr/data             accumulator buffer read (data one cycle later)
//   bias_rd_en/addr/data            bias buffer read (data one cycle later)
//   rq_en, rq_in_acc, rq_bias,
//   rq_mult/shift/symmetric/zp_out  requantizer inputs and latched config
//   rq_out_q, rq_out_valid          requantizer results (3 cycles after rq_en)
//   out_wr_valid/ready/addr/data    output buffer write port
//   busy, done, err_ovf             status: job active, completion pulse, sticky overflow
module requant_seq_ctrl #(
  parameter int LANES      = 16,
  parameter int ACC_BITS   = 32,
  parameter int OUT_BITS   = 8,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       start,
  input  logic [ADDR_W:0]            cfg_rows,
  input  logic [ADDR_W-1:0]          cfg_acc_base,
  input  logic [ADDR_W-1:0]          cfg_bias_addr,
  input  logic [ADDR_W-1:0]          cfg_out_base,
  input  logic [31:0]                cfg_mult,
  input  logic [5:0]                 cfg_shift,
  input  logic                       cfg_symmetric,
  input  logic [7:0]                 cfg_zp_out,
  output logic                       acc_rd_en,
  output logic [ADDR_W-1:0]          acc_rd_addr,
  input  logic [LANES*ACC_BITS-1:0]  acc_rd_data,
  output logic                       bias_rd_en,
  output logic [ADDR_W-1:0]          bias_rd_addr,
  input  logic [LANES*32-1:0]        bias_rd_data,
  output logic                       rq_en,
  output logic [LANES*ACC_BITS-1:0]  rq_in_acc,
  output logic [LANES*32-1:0]        rq_bias,
  output logic [31:0]                rq_mult,
  output logic [5:0]                 rq_shift,
  output logic                       rq_symmetric,
  output logic [7:0]                 rq_zp_out,
  input  logic [LANES*OUT_BITS-1:0]  rq_out_q,
  input  logic                       rq_out_valid,
  output logic                       out_wr_valid,
  input  logic                       out_wr_ready,
  output logic [ADDR_W-1:0]          out_wr_addr,
  output logic [LANES*OUT_BITS-1:0]  out_wr_data,
  output logic                       busy,
  output logic                       done,
  output logic                       err_ovf
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_BIAS_RD, S_BIAS_WAIT, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W:0]   rows_q;
  logic [ADDR_W-1:0] acc_base_q;
  logic [ADDR_W-1:0] bias_addr_q;
  logic [ADDR_W-1:0] out_base_q;
  logic [ADDR_W:0]   issued, issued_inc;
  logic [ADDR_W:0]   written, written_nxt;
  logic [CW-1:0]     inflight, inflight_nxt;
  logic [CW-1:0]     fifo_count, fifo_count_nxt;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW:0]       occupancy;
  logic              credit_ok;
  logic              fifo_full;
  logic              push, push_ok, pop;

  logic [LANES*OUT_BITS-1:0] fifo_mem [FIFO_DEPTH];

  // Credit covers both vectors still inside the requantizer and results
  // already queued; a same-cycle pop is deliberately not credited.
  assign occupancy = {1'b0, fifo_count} + {1'b0, inflight};
  assign credit_ok = occupancy < (CW+1)'(FIFO_DEPTH);

  assign acc_rd_en    = (state == S_RUN) && (issued < rows_q) && credit_ok;
  assign acc_rd_addr  = acc_base_q + issued[ADDR_W-1:0];
  assign bias_rd_en   = (state == S_BIAS_RD);
  assign bias_rd_addr = bias_addr_q;
  assign rq_in_acc    = acc_rd_data;
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);

  assign fifo_full    = (fifo_count == CW'(FIFO_DEPTH));
  assign out_wr_valid = (fifo_count != '0);
  assign out_wr_data  = out_wr_valid ? fifo_mem[rd_ptr] : '0;
  assign out_wr_addr  = out_base_q + written[ADDR_W-1:0];
  assign push         = rq_out_valid;
  assign pop          = out_wr_valid && out_wr_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok      = push && (!fifo_full || pop);

  assign issued_inc  = issued + (ADDR_W+1)'(1);
  assign written_nxt = written + {{ADDR_W{1'b0}}, pop};

  always_comb begin
    inflight_nxt = inflight;
    if (acc_rd_en && !rq_out_valid)
      inflight_nxt = inflight + CW'(1);
    else if (!acc_rd_en && rq_out_valid)
      inflight_nxt = inflight - CW'(1);
  end

  always_comb begin
    fifo_count_nxt = fifo_count;
    if (push_ok && !pop)
      fifo_count_nxt = fifo_count + CW'(1);
    else if (!push_ok && pop)
      fifo_count_nxt = fifo_count - CW'(1);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // DRAIN looks at next-cycle counter values so DONE follows the final pop
  // directly instead of one idle cycle later.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start)
          state_nxt = (cfg_rows == '0) ? S_DONE : S_BIAS_RD;
      end
      S_BIAS_RD:   state_nxt = S_BIAS_WAIT;
      S_BIAS_WAIT: state_nxt = S_RUN;
      S_RUN: begin
        if (acc_rd_en && (issued_inc == rows_q))
          state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if ((inflight_nxt == '0) && (fifo_count_nxt == '0) && (written_nxt == rows_q))
          state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rows_q       <= '0;
      acc_base_q   <= '0;
      bias_addr_q  <= '0;
      out_base_q   <= '0;
      issued       <= '0;
      written      <= '0;
      inflight     <= '0;
      fifo_count   <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rq_en        <= 1'b0;
      rq_bias      <= '0;
      rq_mult      <= '0;
      rq_shift     <= '0;
      rq_symmetric <= 1'b0;
      rq_zp_out    <= '0;
      err_ovf      <= 1'b0;
    end else begin
      if ((state == S_IDLE) && start) begin
        rows_q       <= cfg_rows;
        acc_base_q   <= cfg_acc_base;
        bias_addr_q  <= cfg_bias_addr;
        out_base_q   <= cfg_out_base;
        rq_mult      <= cfg_mult;
        rq_shift     <= cfg_shift;
        rq_symmetric <= cfg_symmetric;
        rq_zp_out    <= cfg_zp_out;
        issued       <= '0;
        written      <= '0;
      end else begin
        if (acc_rd_en) issued  <= issued_inc;
        if (pop)       written <= written_nxt;
      end
      if (state == S_BIAS_WAIT)
        rq_bias <= bias_rd_data;
      rq_en      <= acc_rd_en;
      inflight   <= inflight_nxt;
      fifo_count <= fifo_count_nxt;
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push && !push_ok)
        err_ovf <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok)
      fifo_mem[wr_ptr] <= rq_out_q;
  end

endmodule

// File: tb/tb_requant_seq_ctrl.sv
// Directed testbench for requant_seq_ctrl with behavioural accumulator/bias
// buffers and a 3-stage requantizer model.
module tb_requant_seq_ctrl;

  localparam int LANES = 16;
  localparam int AW    = 10;

  logic                CLK, RESET, start;
  logic [AW:0]         cfg_rows;
  logic [AW-1:0]       cfg_acc_base, cfg_bias_addr, cfg_out_base;
  logic [31:0]         cfg_mult;
  logic [5:0]          cfg_shift;
  logic                cfg_symmetric;
  logic [7:0]          cfg_zp_out;
  logic                acc_rd_en, bias_rd_en, rq_en, rq_out_valid;
  logic [AW-1:0]       acc_rd_addr, bias_rd_addr, out_wr_addr;
  logic [511:0]        acc_rd_data, bias_rd_data, rq_in_acc, rq_bias;
  logic [31:0]         rq_mult;
  logic [5:0]          rq_shift;
  logic                rq_symmetric;
  logic [7:0]          rq_zp_out;
  logic [127:0]        rq_out_q, out_wr_data;
  logic                out_wr_valid, out_wr_ready, busy, done, err_ovf;

  requant_seq_ctrl #(.LANES(16), .ACC_BITS(32), .OUT_BITS(8), .ADDR_W(10), .FIFO_DEPTH(8)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .cfg_rows(cfg_rows),
    .cfg_acc_base(cfg_acc_base), .cfg_bias_addr(cfg_bias_addr), .cfg_out_base(cfg_out_base),
    .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .cfg_symmetric(cfg_symmetric), .cfg_zp_out(cfg_zp_out),
    .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr), .acc_rd_data(acc_rd_data),
    .bias_rd_en(bias_rd_en), .bias_rd_addr(bias_rd_addr), .bias_rd_data(bias_rd_data),
    .rq_en(rq_en), .rq_in_acc(rq_in_acc), .rq_bias(rq_bias), .rq_mult(rq_mult),
    .rq_shift(rq_shift), .rq_symmetric(rq_symmetric), .rq_zp_out(rq_zp_out),
    .rq_out_q(rq_out_q), .rq_out_valid(rq_out_valid),
    .out_wr_valid(out_wr_valid), .out_wr_ready(out_wr_ready), .out_wr_addr(out_wr_addr),
    .out_wr_data(out_wr_data), .busy(busy), .done(done), .err_ovf(err_ovf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [511:0] acc_vec(input int addr);
    logic [511:0] v;
    for (int l = 0; l < LANES; l++) v[l*32 +: 32] = 32'(addr * 37 + l * 1000 - 5000);
    return v;
  endfunction

  function automatic logic [511:0] bias_vec(input int addr);
    logic [511:0] v;
    for (int l = 0; l < LANES; l++) v[l*32 +: 32] = 32'(addr * 3 + l * 11 - 60);
    return v;
  endfunction

  function automatic logic [127:0] rq_core(input logic [511:0] av, input logic [511:0] bv,
                                           input logic [31:0] m, input logic [5:0] sh,
                                           input logic sym, input logic [7:0] zp);
    logic [127:0] r;
    longint t;
    for (int l = 0; l < LANES; l++) begin
      t = longint'($signed(av[l*32 +: 32])) + longint'($signed(bv[l*32 +: 32]));
      t = t * longint'($signed(m));
      t = t >>> sh;
      if (!sym) t = t + longint'($signed(zp));
      if (t > 127) t = 127;
      else if (t < -128) t = -128;
      r[l*8 +: 8] = t[7:0];
    end
    return r;
  endfunction

  // Buffers: read data one cycle after the strobe
  always @(posedge CLK) begin
    if (acc_rd_en)  acc_rd_data  <= acc_vec(int'(acc_rd_addr));
    if (bias_rd_en) bias_rd_data <= bias_vec(int'(bias_rd_addr));
  end

  // Requantizer: rq_en in, rq_out_valid three cycles later
  logic         v1, v2, v3;
  logic [127:0] q1, q2, q3;
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      q1 <= '0;   q2 <= '0;   q3 <= '0;
    end else begin
      v1 <= rq_en;
      if (rq_en) q1 <= rq_core(rq_in_acc, rq_bias, rq_mult, rq_shift, rq_symmetric, rq_zp_out);
      v2 <= v1; q2 <= q1;
      v3 <= v2; q3 <= q2;
    end
  end
  assign rq_out_valid = v3;
  assign rq_out_q     = q3;

  // Event logs (absolute cycle numbers), sampled on the falling edge
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int           bias_cyc_q[$], rd_q[$], rd_cyc_q[$], rqen_cyc_q[$], rqv_cyc_q[$];
  int           wv_cyc_q[$], wa_q[$], done_cyc_q[$], rise_q[$], fall_q[$];
  logic [127:0] wd_q[$];
  int           nrd = 0, npop = 0, max_occ = 0;
  logic         prev_busy = 1'b0;

  always @(negedge CLK) begin
    if (!RESET) begin
      nrd <= 0; npop <= 0; prev_busy <= 1'b0;
    end else begin
      if (nrd - npop > max_occ) max_occ <= nrd - npop;
      if (bias_rd_en) bias_cyc_q.push_back(cyc);
      if (acc_rd_en) begin
        rd_q.push_back(int'(acc_rd_addr)); rd_cyc_q.push_back(cyc); nrd <= nrd + 1;
      end
      if (rq_en)        rqen_cyc_q.push_back(cyc);
      if (rq_out_valid) rqv_cyc_q.push_back(cyc);
      if (out_wr_valid) wv_cyc_q.push_back(cyc);
      if (out_wr_valid && out_wr_ready) begin
        wa_q.push_back(int'(out_wr_addr)); wd_q.push_back(out_wr_data); npop <= npop + 1;
      end
      if (done)               done_cyc_q.push_back(cyc);
      if (busy && !prev_busy) rise_q.push_back(cyc);
      if (!busy && prev_busy) fall_q.push_back(cyc);
      prev_busy <= busy;
    end
  end

  int n_tests = 0, n_fail = 0;
  int t0, b0, rd0, rqen0, rqv0, wv0, w0, d0, rise0, fall0;
  int j_rows, j_abase, j_baddr, j_obase;
  logic [31:0] j_m;
  logic [5:0]  j_sh;
  logic        j_sym;
  logic [7:0]  j_zp;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int first_rel(input int q[$], input int idx);
    if (q.size() > idx) return q[idx] - t0 + 1;
    return -1;
  endfunction

  task automatic do_start(input int rows, input int abase, input int baddr, input int obase,
                          input logic [31:0] m, input logic [5:0] sh, input logic sym,
                          input logic [7:0] zp);
    @(posedge CLK); #1;
    cfg_rows = 11'(rows); cfg_acc_base = 10'(abase); cfg_bias_addr = 10'(baddr);
    cfg_out_base = 10'(obase); cfg_mult = m; cfg_shift = sh; cfg_symmetric = sym; cfg_zp_out = zp;
    j_rows = rows; j_abase = abase; j_baddr = baddr; j_obase = obase;
    j_m = m; j_sh = sh; j_sym = sym; j_zp = zp;
    b0 = bias_cyc_q.size(); rd0 = rd_q.size(); rqen0 = rqen_cyc_q.size();
    rqv0 = rqv_cyc_q.size(); wv0 = wv_cyc_q.size(); w0 = wa_q.size();
    d0 = done_cyc_q.size(); rise0 = rise_q.size(); fall0 = fall_q.size();
    start = 1'b1;
    @(posedge CLK); #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cyc_q.size() == d0 && k < budget) begin
      @(posedge CLK); k++;
    end
    chk("done_seen", 128'(done_cyc_q.size() > d0), 1);
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic check_job();
    int nr, nw;
    nr = rd_q.size() - rd0;
    nw = wa_q.size() - w0;
    chk("rd_count", nr, j_rows);
    for (int i = 0; i < nr && i < j_rows; i++)
      chk("rd_addr", rd_q[rd0+i], (j_abase + i) % 1024);
    chk("wr_count", nw, j_rows);
    for (int i = 0; i < nw && i < j_rows; i++) begin
      chk("wr_addr", wa_q[w0+i], (j_obase + i) % 1024);
      chk("wr_data", wd_q[w0+i],
          rq_core(acc_vec((j_abase + i) % 1024), bias_vec(j_baddr), j_m, j_sh, j_sym, j_zp));
    end
    chk("done_count", done_cyc_q.size() - d0, 1);
    chk("err_ovf", err_ovf, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, {acc_rd_en, bias_rd_en, rq_en, out_wr_valid, busy, done, err_ovf, rq_symmetric}, 0);
    chk({tag, "_addr"}, {acc_rd_addr, bias_rd_addr, out_wr_addr}, 0);
    chk({tag, "_cfg"},  {rq_mult, rq_shift, rq_zp_out}, 0);
    chk({tag, "_bias"}, 128'(|rq_bias), 0);
    chk({tag, "_data"}, out_wr_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    RESET = 1'b0; start = 1'b0; out_wr_ready = 1'b1;
    cfg_rows = '0; cfg_acc_base = '0; cfg_bias_addr = '0; cfg_out_base = '0;
    cfg_mult = '0; cfg_shift = '0; cfg_symmetric = 1'b0; cfg_zp_out = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset");
    RESET = 1'b1;
    repeat (2) @(posedge CLK);

    // Basic single-row job with latency checks
    do_start(1, 5, 2, 9, 32'd5, 6'd8, 1'b0, 8'hfd);
    wait_done(40);
    chk("b_bias_cyc", first_rel(bias_cyc_q, b0), 1);
    chk("b_bias_cnt", bias_cyc_q.size() - b0, 1);
    chk("b_acc_cyc",  first_rel(rd_cyc_q, rd0), 3);
    chk("b_rqen_cyc", first_rel(rqen_cyc_q, rqen0), 4);
    chk("b_rqv_cyc",  first_rel(rqv_cyc_q, rqv0), 7);
    chk("b_wv_cyc",   first_rel(wv_cyc_q, wv0), 8);
    chk("b_done_cyc", first_rel(done_cyc_q, d0), 9);
    chk("b_busy_rise", first_rel(rise_q, rise0), 1);
    chk("b_busy_fall", first_rel(fall_q, fall0), 10);
    chk("b_bias_vec", 128'(rq_bias === bias_vec(2)), 1);
    check_job();

    // Streaming at full throughput
    do_start(64, 100, 20, 200, 32'd7, 6'd6, 1'b0, 8'd5);
    wait_done(200);
    chk("s_rd_span", (rd_q.size() - rd0 == 64) ? rd_cyc_q[rd0+63] - rd_cyc_q[rd0] : -1, 63);
    check_job();

    // Backpressure, ignored start while busy, config isolation
    do_start(32, 300, 7, 400, 32'd3, 6'd5, 1'b1, 8'd10);
    cfg_mult = 32'd77; cfg_shift = 6'd1; cfg_zp_out = 8'hce; cfg_symmetric = 1'b0; cfg_rows = 11'd5;
    for (int i = 0; i < 12; i++) begin
      out_wr_ready = (i % 3 == 0);
      start = (i == 4);
      @(posedge CLK); #1;
    end
    start = 1'b0;
    chk("iso_cfg", {rq_mult, rq_shift, rq_symmetric, rq_zp_out}, {32'd3, 6'd5, 1'b1, 8'd10});
    out_wr_ready = 1'b0;
    repeat (20) begin @(posedge CLK); #1; end
    chk("bp_busy", busy, 1);
    chk("bp_err_hold", err_ovf, 0);
    out_wr_ready = 1'b1;
    wait_done(400);
    check_job();
    chk("bp_max_occ", max_occ, 8);
    chk("bp_rise_cnt", rise_q.size() - rise0, 1);

    // Zero-row job
    do_start(0, 50, 3, 60, 32'd1, 6'd0, 1'b0, 8'd0);
    wait_done(10);
    chk("z_done_cyc", first_rel(done_cyc_q, d0), 1);
    chk("z_rd_cnt",   rd_q.size() - rd0, 0);
    chk("z_bias_cnt", bias_cyc_q.size() - b0, 0);
    chk("z_done_cnt", done_cyc_q.size() - d0, 1);

    // Address wrap on reads and writes, negative multiplier
    do_start(8, 1020, 1023, 1022, 32'hffff_fff6, 6'd3, 1'b0, 8'd0);
    wait_done(60);
    check_job();

    // Reset in the middle of RUN
    do_start(64, 500, 1, 600, 32'd2, 6'd4, 1'b0, 8'd1);
    repeat (5) @(posedge CLK);
    #2;
    chk("mr_running", {busy, acc_rd_en}, 2'b11);
    RESET = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
    repeat (20) @(posedge CLK);
    #1;
    chk("mr_no_done", done_cyc_q.size() - d0, 0);
    chk("mr_idle", {busy, out_wr_valid, acc_rd_en}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
